hex_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for a common-digit hex display. It sits directly upstream of the hex-to-7-segment decoder and feeds it one nibble at a time. It holds an NDIGITS-wide hex value and steps through the digits at a prescaled rate, driving the active-low digit selects. Features: tear-free value updates at frame boundaries, ghosting dead-time, per-digit blanking and leading-zero suppression.

---
 rtl/hex_scan_ctrl.sv | 95 +++++++++
 tb/tb_hex_scan_ctrl.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/hex_scan_ctrl.sv
// hex_scan_ctrl: time-multiplexed scan controller for a common-digit hex display
// Ports:
//   clk        system clock
//   reset      synchronous reset, active-high
//   wr         one-cycle strobe loading din/blank_mask into the shadow
//   din        value to display, din[3:0] is digit 0 (rightmost)
//   blank_mask per-digit force-blank, captured with wr
//   lz_en      leading-zero suppression enable (sampled live)
//   nibble     hex value of the current digit (valid even when blanked)
//   dig_n      active-low digit selects, at most one low
//   blank      current slot is blanked
//   frame      one-cycle pulse at the start of the digit-0 slot
module hex_scan_ctrl #(
    parameter int NDIGITS = 4,
    parameter int PRESC   = 50000,
    parameter int DEAD    = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr,
    input  logic [4*NDIGITS-1:0]   din,
    input  logic [NDIGITS-1:0]     blank_mask,
    input  logic                   lz_en,
    output logic [3:0]             nibble,
    output logic [NDIGITS-1:0]     dig_n,
    output logic                   blank,
    output logic                   frame
);
    localparam int CW = $clog2(PRESC);
    localparam int IW = $clog2(NDIGITS);
    logic [CW-1:0]          r_cnt;
    logic [IW-1:0]          r_idx;
    logic [4*NDIGITS-1:0]   r_disp, r_shadow;
    logic [NDIGITS-1:0]     r_mask, r_shmask;
    logic                   r_pending, r_started;
    logic                   w_tick, w_last, w_wrap, w_dead, w_supp, w_blank_now;
    logic [NDIGITS-1:0]     w_hi_zero;
    assign w_tick = r_cnt == CW'(PRESC - 1);
    assign w_last = r_idx == IW'(NDIGITS - 1);
    assign w_wrap = w_tick && w_last;
    assign w_dead = int'(r_cnt) < DEAD;
    // w_hi_zero[i]: nibbles i..NDIGITS-1 of the active value are all zero
    always_comb begin
        logic z;
        z = 1'b1;
        w_hi_zero = '0;
        for (int i = NDIGITS - 1; i >= 0; i--) begin
            z = z && (r_disp[4*i +: 4] == 4'd0);
            w_hi_zero[i] = z;
        end
    end
    assign w_supp      = lz_en && (r_idx != '0) && w_hi_zero[r_idx];
    assign w_blank_now = r_mask[r_idx] || w_supp;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt     <= '0;
            r_idx     <= '0;
            r_disp    <= '0;
            r_mask    <= '0;
            r_shadow  <= '0;
            r_shmask  <= '0;
            r_pending <= 1'b0;
            r_started <= 1'b0;
            nibble    <= '0;
            dig_n     <= '1;
            blank     <= 1'b0;
            frame     <= 1'b0;
        end else begin
            r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
            if (w_tick)
                r_idx <= w_last ? '0 : r_idx + 1'b1;
            // new values only take effect at the frame boundary; a write on
            // the wrap cycle itself bypasses the shadow
            if (w_wrap) begin
                r_pending <= 1'b0;
                r_started <= 1'b1;
                if (wr) begin
                    r_disp <= din;
                    r_mask <= blank_mask;
                end else if (r_pending) begin
                    r_disp <= r_shadow;
                    r_mask <= r_shmask;
                end
            end else if (wr) begin
                r_shadow  <= din;
                r_shmask  <= blank_mask;
                r_pending <= 1'b1;
            end
            nibble <= r_disp[4*r_idx +: 4];
            blank  <= w_blank_now;
            dig_n  <= (w_dead || w_blank_now) ? '1 : ~(NDIGITS'(1) << r_idx);
            frame  <= (r_idx == '0) && (r_cnt == '0) && r_started;
        end
    end
endmodule

// File: tb/tb_hex_scan_ctrl.sv
// tb_hex_scan_ctrl: scoreboard bench for hex_scan_ctrl with directed frame checks
module tb_hex_scan_ctrl;
    localparam int N = 4;
    localparam int P = 8;
    localparam int D = 2;
    logic        clk = 1'b0;
    logic        reset, wr, lz_en;
    logic [15:0] din;
    logic [3:0]  blank_mask;
    logic [3:0]  nibble, dig_n;
    logic        blank, frame;
    int          n_chk = 0;
    int          n_bad = 0;
    logic [9:0]  sb[$];
    hex_scan_ctrl #(.NDIGITS(N), .PRESC(P), .DEAD(D)) dut (
        .clk(clk), .reset(reset), .wr(wr), .din(din), .blank_mask(blank_mask),
        .lz_en(lz_en), .nibble(nibble), .dig_n(dig_n), .blank(blank), .frame(frame)
    );
    always #5 clk = ~clk;
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask
    // reference model: expected outputs pushed at each edge, compared one half-cycle later
    int          m_cnt, m_idx;
    logic [15:0] m_disp, m_shadow;
    logic [3:0]  m_mask, m_shmask;
    bit          m_pend, m_started;
    always @(posedge clk) begin
        logic [9:0] e;
        logic [3:0] nib;
        bit         bn;
        if (reset) begin
            e = {4'h0, 4'hF, 1'b0, 1'b0};
            m_cnt = 0; m_idx = 0; m_disp = 0; m_shadow = 0;
            m_mask = 0; m_shmask = 0; m_pend = 0; m_started = 0;
        end else begin
            nib = 4'((m_disp >> (4 * m_idx)) & 16'hF);
            bn  = m_mask[m_idx] || (lz_en && m_idx > 0 && (m_disp >> (4 * m_idx)) == 16'h0);
            e = {nib, (m_cnt < D || bn) ? 4'hF : 4'(~(1 << m_idx)), bn,
                 (m_idx == 0 && m_cnt == 0 && m_started)};
            if (m_cnt == P - 1 && m_idx == N - 1) begin
                if (wr) begin
                    m_disp = din; m_mask = blank_mask;
                end else if (m_pend) begin
                    m_disp = m_shadow; m_mask = m_shmask;
                end
                m_pend = 0;
                m_started = 1;
            end else if (wr) begin
                m_shadow = din; m_shmask = blank_mask; m_pend = 1;
            end
            if (m_cnt == P - 1) begin
                m_cnt = 0;
                m_idx = (m_idx + 1) % N;
            end else
                m_cnt++;
        end
        sb.push_back(e);
    end
    always @(negedge clk) begin
        logic [9:0] e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("cyc", {22'd0, nibble, dig_n, blank, frame}, {22'd0, e});
        end
    end
    task automatic write(input logic [15:0] v, input logic [3:0] m);
        wr = 1'b1; din = v; blank_mask = m;
        @(negedge clk);
        wr = 1'b0;
    endtask
    task automatic wait_frame(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!frame && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!frame) chk({tag, "_to"}, 32'd0, 32'd1);
    endtask
    task automatic check_frame(input string tag, input logic [15:0] v, input logic [3:0] bm);
        int d;
        wait_frame(tag);
        for (int t = 1; t < N * P; t++) begin
            @(negedge clk);
            if (t % P == D) begin
                d = t / P;
                chk({tag, "_nib"}, {28'd0, nibble}, {28'd0, v[4*d +: 4]});
                chk({tag, "_blk"}, {31'd0, blank}, {31'd0, bm[d]});
                chk({tag, "_dig"}, {28'd0, dig_n}, {28'd0, bm[d] ? 4'hF : 4'(~(1 << d))});
            end
        end
    endtask
    task automatic wr_on_wrap(input logic [15:0] v);
        wait_frame("wrap");
        repeat (N * P - 2) @(negedge clk);
        write(v, 4'h0);
    endtask
    initial begin
        reset = 1'b1; wr = 1'b0; din = '0; blank_mask = '0; lz_en = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rel_dig", {28'd0, dig_n}, 32'hF);
        chk("rel_frm", {31'd0, frame}, 32'd0);
        check_frame("init", 16'h0000, 4'h0);
        repeat (9) @(negedge clk);
        write(16'h12AB, 4'h0);
        check_frame("v12ab", 16'h12AB, 4'h0);
        write(16'h1111, 4'h0);
        repeat (3) @(negedge clk);
        write(16'h2222, 4'h0);
        check_frame("last", 16'h2222, 4'h0);
        wr_on_wrap(16'h3333);
        check_frame("bypass", 16'h3333, 4'h0);
        check_frame("hold", 16'h3333, 4'h0);
        lz_en = 1'b1;
        write(16'h0040, 4'h0);
        check_frame("lz40", 16'h0040, 4'b1100);
        write(16'h0000, 4'h0);
        check_frame("lz0", 16'h0000, 4'b1110);
        lz_en = 1'b0;
        write(16'hBEEF, 4'b0101);
        check_frame("mask", 16'hBEEF, 4'b0101);
        wait_frame("pre_rst");
        repeat (10) @(negedge clk);
        write(16'h7777, 4'h0);
        repeat (8) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_nib", {28'd0, nibble}, 32'd0);
        chk("rst_dig", {28'd0, dig_n}, 32'hF);
        chk("rst_blk", {31'd0, blank}, 32'd0);
        reset = 1'b0;
        check_frame("after_rst", 16'h0000, 4'h0);
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
